// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage with tagged instruction buffer
// Drives imem from the fetch PC, buffers {word, pc} pairs and hands them out over valid/ready.
module ifetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_iaddr,
  input  logic [DATA_W-1:0] imem_idata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fetch_count
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [2:0]        r_count;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [31:0]       r_fetch_count;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_pcs  [DEPTH];

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic [3:0] w_occ;
  logic       w_unused_rpc_lo;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_unused_rpc_lo = ^redirect_pc[1:0];

  assign inst_valid  = (r_count != 3'd0);
  assign inst        = inst_valid ? r_data[r_head] : '0;
  assign inst_pc     = inst_valid ? r_pcs[r_head]  : '0;
  assign imem_iaddr  = r_fetch_pc;
  assign fetch_count = r_fetch_count;

  // Occupancy counts the in-flight word so the buffer can never be overrun.
  assign w_pop   = inst_valid & inst_ready;
  assign w_occ   = 4'(r_count) + 4'(r_inflight) - 4'(w_pop);
  assign w_issue = !redirect && (w_occ < 4'(DEPTH));
  assign w_push  = r_inflight & !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_count       <= 3'd0;
      r_head        <= '0;
      r_tail        <= '0;
      r_fetch_count <= 32'd0;
    end else begin
      if (w_pop) r_fetch_count <= r_fetch_count + 32'd1;
      if (redirect) begin
        r_count    <= 3'd0;
        r_head     <= '0;
        r_tail     <= '0;
        r_inflight <= 1'b0;
        r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_inflight_pc <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
        end
        if (w_push) r_tail <= next_ptr(r_tail);
        if (w_pop)  r_head <= next_ptr(r_head);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 3'd1;
          2'b01:   r_count <= r_count - 3'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= imem_idata;
      r_pcs[r_tail]  <= r_inflight_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) r_count <= 3'(DEPTH));

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed table-driven bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_iaddr;
  logic [31:0] imem_idata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  int n_pass;
  int n_total;
  int exp_fc;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] iaddr;
  } vec_t;

  vec_t tbl[$];

  ifetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_iaddr(imem_iaddr), .imem_idata(imem_idata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  // Synchronous-read instruction memory.
  initial imem_idata = 32'd0;
  always @(posedge clk) imem_idata <= mem_word(imem_iaddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic r, input logic rd, input logic [31:0] rpc,
                     input logic v, input logic [31:0] pc, input logic [31:0] ia);
    vec_t e;
    e.ready = r; e.redir = rd; e.rpc = rpc; e.valid = v; e.pc = pc; e.iaddr = ia;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_iaddr", imem_iaddr, 32'd0);
    check("rst_fc", fetch_count, 32'd0);
    rst_n = 1'b1;
    exp_fc = 0;
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      inst_ready  = tbl[i].ready;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      check($sformatf("valid[%0d]", i), 32'(inst_valid), 32'(tbl[i].valid));
      check($sformatf("inst_pc[%0d]", i), inst_pc, tbl[i].valid ? tbl[i].pc : 32'd0);
      check($sformatf("inst[%0d]", i), inst, tbl[i].valid ? mem_word(tbl[i].pc) : 32'd0);
      check($sformatf("iaddr[%0d]", i), imem_iaddr, tbl[i].iaddr);
      check($sformatf("fcount[%0d]", i), fetch_count, 32'(exp_fc));
      if (tbl[i].valid && tbl[i].ready) exp_fc++;
      @(posedge clk);
      #1;
    end
    inst_ready = 1'b0;
    redirect   = 1'b0;
    tbl.delete();
  endtask

  initial begin
    n_pass = 0; n_total = 0; exp_fc = 0;

    // Streaming from reset with ready held high.
    do_reset();
    add(1, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 0, 32'h4);
    for (int k = 2; k <= 12; k++) add(1, 0, 0, 1, 32'(4 * (k - 2)), 32'(4 * k));
    run_table();
    check("fc_after_10", fetch_count, 32'd11);

    // Backpressure, redirect on a full buffer, redirect with pop, PC wrap.
    do_reset();
    add(1, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 0, 32'h4);
    for (int k = 2; k <= 7; k++) add(0, 0, 0, 1, 32'h0, 32'h8);
    add(1, 0, 0,              1, 32'h0,        32'h8);
    add(1, 0, 0,              1, 32'h4,        32'hC);
    add(1, 0, 0,              1, 32'h8,        32'h10);
    add(0, 0, 0,              1, 32'hC,        32'h14);
    add(0, 1, 32'h0000_0203,  1, 32'hC,        32'h14);
    add(1, 0, 0,              0, 0,            32'h200);
    add(1, 0, 0,              0, 0,            32'h204);
    add(1, 0, 0,              1, 32'h200,      32'h208);
    add(1, 1, 32'hFFFF_FFF8,  1, 32'h204,      32'h20C);
    add(1, 0, 0,              0, 0,            32'hFFFF_FFF8);
    add(1, 0, 0,              0, 0,            32'hFFFF_FFFC);
    add(1, 0, 0,              1, 32'hFFFF_FFF8, 32'h0);
    add(1, 0, 0,              1, 32'hFFFF_FFFC, 32'h4);
    add(1, 0, 0,              1, 32'h0,        32'h8);
    add(1, 0, 0,              1, 32'h4,        32'hC);
    run_table();

    // Asynchronous reset between edges while streaming.
    inst_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(inst_valid), 32'd0);
    check("async_inst", inst, 32'd0);
    check("async_pc", inst_pc, 32'd0);
    check("async_iaddr", imem_iaddr, 32'h0);
    check("async_fc", fetch_count, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_fc = 0;
    add(1, 0, 0, 0, 0,     32'h0);
    add(1, 0, 0, 0, 0,     32'h4);
    add(1, 0, 0, 1, 32'h0, 32'h8);
    add(1, 0, 0, 1, 32'h4, 32'hC);
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
